sfa_vop: RTL and testbench



---
 rtl/sfa_pkg.sv | 24 ++
 rtl/sfa_fifo2.sv | 63 ++++++
 rtl/sfa_vop.sv | 112 +++++++++++
 tb/tb_sfa_vop.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfa_pkg.sv
// sfa_pkg: shared types and defaults for the SFA stream stages.
//   - sfa_state_e : one-hot control FSM encoding (IDLE/RUN/DRAIN/DONE)
//   - vop_op_e    : element-wise operator codes driven on the OP port
//   - DATA_W_DEF / CNT_W_DEF : default data and element-counter widths
package sfa_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 24;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_RUN   = 4'b0010,
        ST_DRAIN = 4'b0100,
        ST_DONE  = 4'b1000
    } sfa_state_e;

    typedef enum logic [1:0] {
        VOP_ADD = 2'd0,
        VOP_SUB = 2'd1,
        VOP_MUL = 2'd2,
        VOP_MAX = 2'd3
    } vop_op_e;

endpackage

// File: rtl/sfa_fifo2.sv
// sfa_fifo2: 2-entry synchronous FIFO for SFA stream stages.
//   ACLK/ARESETN : clock, async active-low reset
//   push/din     : write strobe and data (ignored when full)
//   pop          : read strobe (ignored when empty)
//   dout         : head entry, straight from a register
//   full/empty   : occupancy flags, decoded from the count register
module sfa_fifo2 #(
    parameter int W = 32
) (
    input  logic         ACLK,
    input  logic         ARESETN,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    // Shift-style storage: head_q is always the oldest entry so dout needs
    // no read mux.
    logic [W-1:0] head_q, tail_q;
    logic [1:0]   cnt_q;
    logic         do_push, do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = head_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= din;
                    else               tail_q <= din;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; with one entry the new word
                    // replaces the departing head directly.
                    if (cnt_q == 2'd1) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sfa_vop.sv
// sfa_vop: streaming element-wise binary operator (R = A op B).
//   ACLK/ARESETN        : clock, async active-low reset
//   sA_* / sB_*         : operand AXI-Stream inputs, consumed as pairs
//   mR_*                : result AXI-Stream output (2-entry FIFO buffered)
//   ap_start/done/idle  : run control; one run = SIZE elements
//   OP                  : 0 add, 1 sub (A-B), 2 mul low bits, 3 signed max
//   SIZE                : element count, latched with OP at start
module sfa_vop
    import sfa_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    output logic              sA_tready,
    input  logic              sA_tvalid,
    input  logic [DATA_W-1:0] sA_tdata,
    output logic              sB_tready,
    input  logic              sB_tvalid,
    input  logic [DATA_W-1:0] sB_tdata,
    input  logic              mR_tready,
    output logic              mR_tvalid,
    output logic [DATA_W-1:0] mR_tdata,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    input  logic [1:0]        OP,
    input  logic [CNT_W-1:0]  SIZE
);

    sfa_state_e        state, state_nxt;
    vop_op_e           op_q;
    logic [CNT_W-1:0]  size_q, in_cnt, out_cnt, in_cnt_nxt, out_cnt_nxt;
    logic              in_rdy, in_fire, out_fire, fifo_full, fifo_empty;
    logic [DATA_W-1:0] res;

    // Readies come only from registered state, so a lone valid on one
    // stream can never leak a handshake on the other.
    assign in_rdy    = (state == ST_RUN) && !fifo_full && (in_cnt != size_q);
    assign sA_tready = in_rdy;
    assign sB_tready = in_rdy;
    assign in_fire   = in_rdy && sA_tvalid && sB_tvalid;

    assign mR_tvalid = !fifo_empty;
    assign out_fire  = mR_tvalid && mR_tready;

    assign in_cnt_nxt  = in_cnt + CNT_W'(in_fire);
    assign out_cnt_nxt = out_cnt + CNT_W'(out_fire);

    assign ap_done = (state == ST_DONE);
    assign ap_idle = (state == ST_IDLE);

    always_comb begin
        res = '0;
        case (op_q)
            VOP_ADD: res = sA_tdata + sB_tdata;
            VOP_SUB: res = sA_tdata - sB_tdata;
            VOP_MUL: res = sA_tdata * sB_tdata;
            VOP_MAX: res = ($signed(sA_tdata) > $signed(sB_tdata)) ? sA_tdata : sB_tdata;
            default: res = '0;
        endcase
    end

    sfa_fifo2 #(.W(DATA_W)) u_ofifo (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .push    (in_fire),
        .din     (res),
        .pop     (out_fire),
        .dout    (mR_tdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Transitions look at next-count values so DONE lands the cycle right
    // after the final output handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ap_start) state_nxt = (SIZE == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (in_cnt_nxt == size_q) state_nxt = ST_DRAIN;
            ST_DRAIN: if (out_cnt_nxt == size_q) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= ST_IDLE;
            op_q    <= VOP_ADD;
            size_q  <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE) begin
                if (ap_start) begin
                    op_q    <= vop_op_e'(OP);
                    size_q  <= SIZE;
                    in_cnt  <= '0;
                    out_cnt <= '0;
                end
            end else begin
                in_cnt  <= in_cnt_nxt;
                out_cnt <= out_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sfa_vop.sv
// tb_sfa_vop: directed bench for sfa_vop with a queue-based reference model.
module tb_sfa_vop;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        sA_tready, sB_tready, mR_tvalid, ap_done, ap_idle;
    logic        sA_tvalid = 1'b0, sB_tvalid = 1'b0, mR_tready = 1'b0, ap_start = 1'b0;
    logic [31:0] sA_tdata = '0, sB_tdata = '0, mR_tdata;
    logic [1:0]  OP = 2'd0;
    logic [23:0] SIZE = '0;

    sfa_vop dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .sA_tready(sA_tready), .sA_tvalid(sA_tvalid), .sA_tdata(sA_tdata),
        .sB_tready(sB_tready), .sB_tvalid(sB_tvalid), .sB_tdata(sB_tdata),
        .mR_tready(mR_tready), .mR_tvalid(mR_tvalid), .mR_tdata(mR_tdata),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
        .OP(OP), .SIZE(SIZE)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0, errors = 0;
    logic [31:0] qa[$], qb[$], exp_q[$], got_q[$];
    logic a_en = 1'b0, b_en = 1'b0;
    int run_op = 0, run_size = 0, consumed = 0, emitted = 0;
    int cyc = 0, last_fire_cyc = -10, start_cyc = -10, done_cnt = 0;
    bit in_run = 1'b0;
    logic [31:0] va[16], vb[16], vr[16];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference operator, straight from the operator definitions.
    function automatic logic [31:0] vop_ref(int op, logic [31:0] a, logic [31:0] b);
        longint prod;
        case (op)
            0: return a + b;
            1: return a - b;
            2: begin prod = longint'(a) * longint'(b); return prod[31:0]; end
            default: return (int'(a) > int'(b)) ? a : b;
        endcase
    endfunction

    // Compare process: tracks the run at the transaction level and checks
    // the DUT every cycle, sampling on the falling edge.
    always @(negedge ACLK) begin
        cyc++;
        if (!ARESETN) begin
            chk("rst_idle", ap_idle, 1);
            chk("rst_done", ap_done, 0);
            chk("rst_ardy", sA_tready, 0);
            chk("rst_brdy", sB_tready, 0);
            chk("rst_rvld", mR_tvalid, 0);
            chk("rst_rdata", mR_tdata, 0);
            exp_q.delete();
            consumed = 0;
            emitted  = 0;
            in_run   = 1'b0;
        end else begin
            chk("idle_flag", ap_idle, !in_run);
            chk("rdy_pair", sA_tready, sB_tready);
            chk("rvld_occ", mR_tvalid, exp_q.size() > 0);
            if (sA_tready)
                chk("rdy_room", (in_run && exp_q.size() < 2 && consumed < run_size), 1);
            if (ap_idle && ap_start) begin
                run_op = int'(OP); run_size = int'(SIZE);
                consumed = 0; emitted = 0; in_run = 1'b1; start_cyc = cyc;
            end
            if (sA_tvalid && sA_tready && sB_tvalid && sB_tready) begin
                exp_q.push_back(vop_ref(run_op, sA_tdata, sB_tdata));
                consumed++;
            end
            if (mR_tvalid && mR_tready) begin
                chk("rdata_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("rdata", mR_tdata, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                got_q.push_back(mR_tdata);
                emitted++;
                last_fire_cyc = cyc;
            end
            if (ap_done) begin
                chk("done_in_run", in_run, 1);
                if (run_size > 0) begin
                    chk("done_count", emitted, run_size);
                    chk("done_timing", cyc, last_fire_cyc + 1);
                end else begin
                    chk("done_timing_zero", cyc, start_cyc + 1);
                end
                in_run = 1'b0;
                done_cnt++;
            end
        end
    end

    task automatic drive();
        sA_tvalid = a_en && (qa.size() > 0);
        sB_tvalid = b_en && (qb.size() > 0);
        sA_tdata  = (qa.size() > 0) ? qa[0] : 32'd0;
        sB_tdata  = (qb.size() > 0) ? qb[0] : 32'd0;
    endtask

    task automatic tick();
        bit fire;
        @(negedge ACLK);
        fire = sA_tvalid && sA_tready && sB_tvalid && sB_tready;
        @(posedge ACLK);
        #1;
        if (fire) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
        end
        drive();
    endtask

    task automatic load(int n);
        qa.delete(); qb.delete(); got_q.delete();
        for (int i = 0; i < n; i++) begin
            qa.push_back(va[i]);
            qb.push_back(vb[i]);
        end
        drive();
    endtask

    // OP and SIZE are scrambled right after start; the run must ignore it.
    task automatic start(int op, int size);
        OP = 2'(op); SIZE = 24'(size); ap_start = 1'b1;
        tick();
        ap_start = 1'b0; OP = 2'(op + 1); SIZE = 24'd1;
    endtask

    task automatic wait_done(string name, int budget);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_done_seen"}, done_cnt != d0, 1);
    endtask

    task automatic chk_lits(string name, int n);
        chk({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk($sformatf("%s_r%0d", name, i), got_q[i], vr[i]);
    endtask

    task automatic run_vec(string name, int op, int n);
        load(n);
        a_en = 1'b1; b_en = 1'b1; mR_tready = 1'b1;
        start(op, n);
        wait_done(name, 200);
        tick();
        chk_lits(name, n);
        chk({name, "_idle_after"}, ap_idle, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        ARESETN = 1'b1;
        tick();

        // add with wrap
        va = '{0:32'd1, 1:32'd2, 2:32'd3, 3:32'hFFFF_FFFF, default:32'd0};
        vb = '{0:32'd10, 1:32'd20, 2:32'd30, 3:32'd1, default:32'd0};
        vr = '{0:32'd11, 1:32'd22, 2:32'd33, 3:32'd0, default:32'd0};
        run_vec("add", 0, 4);

        // sub / mul / max on a signed-interesting set
        va = '{0:32'd5, 1:32'hFFFF_FFFD, 2:32'h0001_0000, default:32'd0};
        vb = '{0:32'd7, 1:32'd4, 2:32'h0001_0000, default:32'd0};
        vr = '{0:32'hFFFF_FFFE, 1:32'hFFFF_FFF9, 2:32'd0, default:32'd0};
        run_vec("sub", 1, 3);
        vr = '{0:32'd35, 1:32'hFFFF_FFF4, 2:32'd0, default:32'd0};
        run_vec("mul", 2, 3);
        vr = '{0:32'd7, 1:32'd4, 2:32'h0001_0000, default:32'd0};
        run_vec("max", 3, 3);

        // SIZE=0: straight to done, nothing else moves
        load(0);
        OP = 2'd0; SIZE = 24'd0; ap_start = 1'b1;
        @(negedge ACLK);
        chk("z_done_c1", ap_done, 0);
        chk("z_rdy_c1", sA_tready, 0);
        @(posedge ACLK); #1;
        ap_start = 1'b0;
        @(negedge ACLK);
        chk("z_done_c2", ap_done, 1);
        chk("z_rvld_c2", mR_tvalid, 0);
        chk("z_rdy_c2", sA_tready, 0);
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("z_done_c3", ap_done, 0);
        chk("z_idle_c3", ap_idle, 1);
        @(posedge ACLK); #1;

        // sink back-pressure: only the FIFO depth gets in
        for (int i = 0; i < 8; i++) begin
            va[i] = 32'(i + 1);
            vb[i] = 32'(10 * (i + 1));
            vr[i] = 32'(11 * (i + 1));
        end
        load(8);
        a_en = 1'b1; b_en = 1'b1; mR_tready = 1'b0;
        start(0, 8);
        repeat (6) tick();
        chk("bp_consumed", consumed, 2);
        chk("bp_rdy_low", sA_tready, 0);
        chk("bp_rvld", mR_tvalid, 1);
        mR_tready = 1'b1;
        wait_done("bp", 200);
        tick();
        chk_lits("bp", 8);

        // lone valid on A must not consume
        va[0] = 32'd7; vb[0] = 32'd8;
        load(1);
        a_en = 1'b1; b_en = 1'b0; mR_tready = 1'b1;
        start(0, 1);
        repeat (5) tick();
        chk("lone_consumed", consumed, 0);
        chk("lone_out", got_q.size(), 0);
        chk("lone_ardy", sA_tready, 1);
        b_en = 1'b1;
        drive();
        tick();
        @(negedge ACLK);
        chk("lone_rvld", mR_tvalid, 1);
        chk("lone_rdata", mR_tdata, 32'd15);
        @(posedge ACLK); #1;
        wait_done("lone", 50);

        // reset mid-run, then a clean short run
        for (int i = 0; i < 16; i++) begin
            va[i] = 32'(i);
            vb[i] = 32'd1;
        end
        load(16);
        a_en = 1'b1; b_en = 1'b1; mR_tready = 1'b1;
        start(0, 16);
        for (int n = 0; n < 200 && emitted < 6; n++) tick();
        chk("mid_reached6", emitted >= 6, 1);
        ARESETN = 1'b0;
        #1;
        chk("mid_rvld", mR_tvalid, 0);
        chk("mid_rdata", mR_tdata, 0);
        chk("mid_ardy", sA_tready, 0);
        chk("mid_idle", ap_idle, 1);
        chk("mid_done", ap_done, 0);
        qa.delete(); qb.delete();
        drive();
        tick();
        ARESETN = 1'b1;
        va = '{0:32'd100, 1:32'd200, default:32'd0};
        vb = '{0:32'd1, 1:32'd2, default:32'd0};
        vr = '{0:32'd101, 1:32'd202, default:32'd0};
        run_vec("post", 0, 2);
        repeat (4) tick();
        chk("post_total", got_q.size(), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
